// File: rtl/count_event_fifo.sv
// count_event_fifo: snapshots the upstream counter on each rising edge of b1_in
// into a small synchronous FIFO. The consumer drains it with an rd_en/rd_valid
// handshake. Occupancy, full/empty and a sticky overflow flag are reported.
module count_event_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] counter_in,
  input  logic             b1_in,
  input  logic             rd_en,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic             b1_q;

  logic evt, rd_acc, wr_acc, drop;

  // Status is decoded from the registered level so it never depends on inputs.
  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));

  // Event detect, handshake qualification and next-state for all control state.
  always_comb begin
    evt        = b1_in & ~b1_q;
    rd_acc     = rd_en & ~empty;
    // A read in the same cycle frees a slot, so a full FIFO can still accept.
    wr_acc     = evt & (~full | rd_acc);
    drop       = evt & full & ~rd_acc;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    ovf_d      = ovf_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A fresh drop outranks a clear in the same cycle.
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // Control registers; b1_q resets high so a level-high b1_in after reset is not an event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      b1_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      b1_q       <= b1_in;
    end
  end

  // Storage array; contents are left alone by reset, writes are blocked during it.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem_q[wr_ptr_q] <= counter_in;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign level    = level_q;
  assign overflow = ovf_q;
endmodule

// File: doc/count_event_fifo.md
# count_event_fifo

Capture stage that sits directly downstream of the counter/flag stage. It watches the stage's 5-bit `counter` and 1-bit `b1` outputs, and snapshots `counter` on every rising edge of `b1` into a small synchronous FIFO. A consumer drains the FIFO through a read-enable/valid handshake. The block reports occupancy, full/empty status and a sticky overflow flag.

## Interface
Parameters:
- `WIDTH`, 5: width of the captured counter value.
- `DEPTH`, 8: number of FIFO entries; power of two, ≥ 2.
- `LW`, `$clog2(DEPTH)+1`: width of `level`; derived, not to be overridden.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `counter_in`  in  WIDTH  counter value from the upstream stage.
- `b1_in`  in  1  event flag from the upstream stage; each rising edge is one capture event.
- `rd_en`  in  1  read request from the consumer.
- `clr_ovf`  in  1  clears `overflow`.
- `rd_data`  out  WIDTH  value popped by the previous accepted read.
- `rd_valid`  out  1  one-cycle strobe; `rd_data` is valid while it is high.
- `empty`  out  1  FIFO holds 0 entries.
- `full`  out  1  FIFO holds DEPTH entries.
- `level`  out  LW  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; at least one event was dropped.

## Operation
- **Edge detect**
  - Register `b1_q <= b1_in`.
  - `evt = b1_in & ~b1_q`.
  - `b1_q` resets to 1, so a `b1_in` that is already high when reset deasserts is not an event.
- **Write**
  - On `evt`, write the `counter_in` value sampled at that same edge to `mem[wr_ptr]` and advance `wr_ptr`.
  - Pointers are `$clog2(DEPTH)` bits wide and wrap naturally (DEPTH-1 → 0).
- **Read**
  - `rd_acc = rd_en & ~empty`.
  - On `rd_acc`: `rd_data <= mem[rd_ptr]`, `rd_ptr` advances, and `rd_valid <= 1`.
  - Otherwise `rd_valid <= 0` and `rd_data` holds its value.
  - `rd_en` while empty is ignored; no error is flagged.
- **Occupancy**
  - `level` is a registered counter: +1 on an accepted write only, −1 on `rd_acc` only, unchanged when both or neither occur.
  - `empty = (level == 0)` and `full = (level == DEPTH)`, both decoded from the registered `level`.
- **Write acceptance**
  - `wr_acc = evt & (~full | rd_acc)`.
  - When full, a simultaneous read frees one slot and the write is accepted. `level` stays at DEPTH and no overflow is flagged.
- **Overflow**
  - If `evt & full & ~rd_acc`, the value is dropped, the pointers are unchanged, and `overflow <= 1`.
  - `clr_ovf` clears `overflow`. If a new drop occurs in the same cycle as `clr_ovf`, set wins.
- **No fall-through**
  - When empty, a write and a read in the same cycle results in the write only.
  - The data becomes readable from the next cycle.
- **Reset** (applies any time `rst_n` is sampled low, including mid-operation)
  - `wr_ptr`, `rd_ptr` and `level` go to 0.
  - `rd_data`, `rd_valid` and `overflow` go to 0; `b1_q` goes to 1.
  - `empty = 1`, `full = 0`.
  - Memory contents are don't-care.
  - No event is captured and no read is accepted in a reset cycle.

## Timing
- **Capture latency:** `b1_in` rising edge sampled at edge N → entry written at edge N → `empty` low and `level` incremented from cycle N+1.
- **Earliest read:** `rd_en` can first be accepted at edge N+1; `rd_data` and `rd_valid` appear after edge N+1.
- **Read latency:** 1 cycle, from `rd_en` sampled to `rd_valid`/`rd_data`.
- **Throughput:** one read per cycle. Back-to-back reads give consecutive `rd_valid` pulses in FIFO order.
- **Event rate:** at most one event per two cycles, because `b1_in` must return low between events.
- **Registered outputs:** `level`, `empty`, `full` and `overflow` are registered and reflect state after the last edge.

## Test plan
- **Reset state:** hold `rst_n = 0` with `b1_in = 1` for 3 cycles, then release with `b1_in` held high → no capture; `level = 0`, `empty = 1`, `full = 0`, `rd_valid = 0`, `overflow = 0`.
- **Single capture:** `counter_in = 5'd17`, pulse `b1_in` high for 1 cycle → `level = 1` the next cycle. Then `rd_en` for 1 cycle → next cycle `rd_data = 17`, `rd_valid = 1` for exactly 1 cycle, `empty = 1`.
- **Fill and wrap:** 8 events with values 3,4,…,10 → `full = 1`, `level = 8`. Drain with continuous `rd_en` → 8 consecutive `rd_valid` cycles returning 3..10 in order. Then 2 more events (11, 12) and read → 11, 12, confirming pointer wrap.
- **Overflow and clear:** with FIFO full, event with value 31 → dropped, `overflow = 1`, `level = 8`, contents unchanged on drain. `clr_ovf` pulse → `overflow = 0`. `clr_ovf` coincident with another drop → `overflow` stays 1.
- **Simultaneous write and read:**
  - Full with `rd_en` on the same cycle as an event of value 9 → oldest value read, 9 accepted, `level = 8`, `overflow = 0`.
  - Empty with `rd_en` and an event of value 5 on the same cycle → `rd_valid = 0`, `level = 1`; a later read returns 5.
- **Reset mid-operation:** load 5 entries, assert `rst_n = 0` for 1 cycle → `level = 0`, `empty = 1`, `rd_valid = 0`. The next event with value 2 followed by a read returns 2.
